// File: rtl/alu_muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider that owns the HI/LO registers.
// Optional signed operation is enabled with the MULDIV_SIGNED_EN macro (adds is_signed).
module alu_muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef MULDIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic              dbz_q, dbz_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // acc holds the product high half or the partial remainder; mpr holds the
  // multiplier/low product or dividend/quotient; mcd holds multiplicand or divisor.
  logic [WIDTH-1:0]  acc_q, acc_d, mpr_q, mpr_d, mcd_q, mcd_d;
  logic              nres_q, nres_d, nrem_q, nrem_d;

  logic              sgn, neg_a, neg_b, last;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [WIDTH:0]    mul_sum;
  logic [2*WIDTH-1:0] prod_n;
  logic [WIDTH:0]    rem_sh;
  logic [WIDTH+1:0]  trial;
  logic              trial_neg;
  logic [WIDTH-1:0]  rem_n, quot_n;

`ifdef MULDIV_SIGNED_EN
  assign sgn = is_signed;
`else
  assign sgn = 1'b0;
`endif

  assign neg_a = sgn & A[WIDTH-1];
  assign neg_b = sgn & B[WIDTH-1];
  assign mag_a = neg_a ? -A : A;
  assign mag_b = neg_b ? -B : B;
  assign last  = (cnt_q == CntW'(WIDTH - 1));

  // Multiply step: add then shift {carry, acc, multiplier} right by one.
  assign mul_sum = {1'b0, acc_q} + (mpr_q[0] ? {1'b0, mcd_q} : '0);
  assign prod_n  = {mul_sum, mpr_q[WIDTH-1:1]};

  // Divide step: shift {rem, quot} left, trial subtract with an extra sign bit.
  assign rem_sh    = {acc_q, mpr_q[WIDTH-1]};
  assign trial     = {1'b0, rem_sh} - {2'b00, mcd_q};
  assign trial_neg = trial[WIDTH+1];
  assign rem_n     = trial_neg ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quot_n    = {mpr_q[WIDTH-2:0], ~trial_neg};

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mpr_d   = mpr_q;
    mcd_d   = mcd_q;
    nres_d  = nres_q;
    nrem_d  = nrem_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          unique case (op)
            2'b00: begin
              mcd_d   = mag_a;
              mpr_d   = mag_b;
              acc_d   = '0;
              cnt_d   = '0;
              dbz_d   = 1'b0;
              nres_d  = neg_a ^ neg_b;
              nrem_d  = 1'b0;
              state_d = StMul;
            end
            2'b01: begin
              if (B == '0) begin
                hi_d    = A;
                lo_d    = '1;
                dbz_d   = 1'b1;
                state_d = StDone;
              end else begin
                mcd_d   = mag_b;
                mpr_d   = mag_a;
                acc_d   = '0;
                cnt_d   = '0;
                dbz_d   = 1'b0;
                nres_d  = neg_a ^ neg_b;
                nrem_d  = neg_a;
                state_d = StDiv;
              end
            end
            2'b10: hi_d = A;
            2'b11: lo_d = A;
          endcase
        end
      end
      StMul: begin
        acc_d = prod_n[2*WIDTH-1:WIDTH];
        mpr_d = prod_n[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          {hi_d, lo_d} = nres_q ? -prod_n : prod_n;
          state_d      = StDone;
        end
      end
      StDiv: begin
        acc_d = rem_n;
        mpr_d = quot_n;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          hi_d    = nrem_q ? -rem_n : rem_n;
          lo_d    = nres_q ? -quot_n : quot_n;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mpr_q   <= '0;
      mcd_q   <= '0;
      nres_q  <= 1'b0;
      nrem_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mpr_q   <= mpr_d;
      mcd_q   <= mcd_d;
      nres_q  <= nres_d;
      nrem_q  <= nrem_d;
    end
  end

  assign busy        = (state_q == StMul) || (state_q == StDiv);
  assign done        = (state_q == StDone);
  assign HI          = hi_q;
  assign LO          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Directed, table-driven bench for alu_muldiv_sequencer (WIDTH=32).
module tb_alu_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = '0, B = '0;
  logic        is_signed = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] HI, LO;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_muldiv_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .A           (A),
    .B           (B),
`ifdef MULDIV_SIGNED_EN
    .is_signed   (is_signed),
`endif
    .busy        (busy),
    .done        (done),
    .HI          (HI),
    .LO          (LO),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
    int          dc, bc;
  } vec_t;

  vec_t vec [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issues one op and follows it until done or a 100-cycle bound.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int dc, output int bc, output bit hold);
    logic [31:0] h0, l0;
    h0 = HI;
    l0 = LO;
    op = o;
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    dc = 0;
    bc = 0;
    hold = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      if (busy) begin
        bc++;
        if (HI !== h0 || LO !== l0) hold = 1'b0;
      end
      if (done) begin
        dc = n;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int dc, bc;
    bit hold;
    bit saw_done;

    vec[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 32};
    vec[1] = '{2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 32};
    vec[2] = '{2'b01, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1, 0};
    vec[3] = '{2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 33, 32};
    vec[4] = '{2'b01, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 33, 32};
    vec[5] = '{2'b01, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0, 33, 32};
    vec[6] = '{2'b00, 32'h8000_0000, 32'd2, 32'd1, 32'd0, 1'b0, 33, 32};
    vec[7] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 33, 32};
    vec[8] = '{2'b01, 32'hDEAD_BEEF, 32'h10, 32'hF, 32'h0DEA_DBEE, 1'b0, 33, 32};

    tick();
    tick();
    reset = 1'b0;
    check("reset_state", {busy, done, div_by_zero, HI, LO}, 67'h0);

    for (int i = 0; i < 9; i++) begin
      run_op(vec[i].op, vec[i].a, vec[i].b, dc, bc, hold);
      check($sformatf("v%0d_done_cycle", i), dc, vec[i].dc);
      check($sformatf("v%0d_busy_cycles", i), bc, vec[i].bc);
      check($sformatf("v%0d_hold", i), hold, 1'b1);
      check($sformatf("v%0d_HI", i), HI, vec[i].hi);
      check($sformatf("v%0d_LO", i), LO, vec[i].lo);
      check($sformatf("v%0d_dbz", i), div_by_zero, vec[i].dbz);
      tick();
      check($sformatf("v%0d_done_pulse", i), {done, busy}, 2'b00);
    end

    // MTHI then MTLO on consecutive edges.
    op = 2'b10; A = 32'hAAAA_0000; start = 1'b1;
    tick();
    check("mthi_HI", HI, 32'hAAAA_0000);
    check("mthi_busy_done", {busy, done}, 2'b00);
    op = 2'b11; A = 32'h0000_BBBB;
    tick();
    start = 1'b0;
    check("mtlo_LO", LO, 32'h0000_BBBB);
    check("mtlo_HI_kept", HI, 32'hAAAA_0000);
    check("mtlo_busy_done", {busy, done}, 2'b00);

    // Start pulsed mid-MULTU is ignored.
    op = 2'b00; A = 32'd6; B = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    op = 2'b10; A = 32'h5555_5555; start = 1'b1;
    tick();
    start = 1'b0;
    check("ignored_start_HI", HI, 32'hAAAA_0000);
    check("ignored_start_busy", busy, 1'b1);
    saw_done = 1'b0;
    for (int n = 0; n < 60 && !saw_done; n++) begin
      if (done) saw_done = 1'b1;
      else tick();
    end
    check("ignored_start_done", saw_done, 1'b1);
    check("ignored_start_prod", {HI, LO}, 64'd42);

    // Reset in cycle 10 of a MULTU aborts it with no done pulse.
    tick();
    op = 2'b00; A = 32'd6; B = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 10; n++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midop_reset", {busy, done, div_by_zero, HI, LO}, 67'h0);
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done || busy) saw_done = 1'b1;
      tick();
    end
    check("no_done_after_reset", saw_done, 1'b0);
    run_op(2'b00, 32'd6, 32'd7, dc, bc, hold);
    check("after_reset_done_cycle", dc, 33);
    check("after_reset_LO", LO, 32'd42);
    tick();

`ifdef MULDIV_SIGNED_EN
    is_signed = 1'b1;
    run_op(2'b01, -32'sd7, 32'd2, dc, bc, hold);
    check("sdiv_done_cycle", dc, 33);
    check("sdiv_LO", LO, 32'hFFFF_FFFD);
    check("sdiv_HI", HI, 32'hFFFF_FFFF);
    tick();
    run_op(2'b00, -32'sd3, 32'd4, dc, bc, hold);
    check("smul_HI", HI, 32'hFFFF_FFFF);
    check("smul_LO", LO, 32'hFFFF_FFF4);
    tick();
    is_signed = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
